// File: rtl/load_store_unit.sv
// RV32 load/store stage: accepts one memory instruction, runs a req/ack bus access,
// aligns and extends load data, and reports completion with a fault code.
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              done,
  output logic [1:0]        fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic [1:0]        fault_q, fault_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              load_q, load_d;

  logic              req_in, illegal, misaligned;
  logic [3:0]        be_new;
  logic [DATA_W-1:0] wdata_new, shifted, ext;

  assign req_in = req_valid & (is_load | is_store);

  // Request decode; loads take priority when both type strobes are high.
  always_comb begin
    illegal    = is_load ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                         : (funct3[2] || funct3[1:0] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    be_new     = 4'b1111;
    wdata_new  = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {(DATA_W/8){store_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << addr[1:0];
        wdata_new = {(DATA_W/16){store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    f3_d        = f3_q;
    load_d      = load_q;
    stall       = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          stall  = 1'b1;
          off_d  = addr[1:0];
          f3_d   = funct3;
          load_d = is_load;
          if (illegal || misaligned) begin
            fault_d = illegal ? 2'b11 : 2'b01;
            state_d = DONE;
            if (is_load) load_data_d = '0;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = ~is_load;
            mem_addr_d  = {addr[DATA_W-1:2], 2'b00};
            mem_be_d    = is_load ? 4'b0000 : be_new;
            mem_wdata_d = is_load ? '0 : wdata_new;
            cnt_d       = '0;
            fault_d     = 2'b00;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        // An ack on the final allowed cycle still completes cleanly.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          fault_d   = 2'b00;
          state_d   = DONE;
          if (load_q) load_data_d = ext;
        end else if (cnt_q == LAST_CNT) begin
          mem_req_d = 1'b0;
          fault_d   = 2'b10;
          state_d   = DONE;
          if (load_q) load_data_d = '0;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      load_data_q <= '0;
      fault_q     <= 2'b00;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      load_q      <= load_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against
// a reference model that computes results straight from the RV32 access rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        mem_req, mem_we, stall, done;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  fault;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ld = '0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .load_data(load_data), .stall(stall), .done(done), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load extraction: pick the addressed byte/halfword arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned off = a % 4;
    int unsigned v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd / (1 << (8 * off))) % 256;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (rd / (1 << (8 * off))) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // d = number of mem_req cycles before the ack cycle; d >= TIMEOUT means no ack.
  task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int d, input logic [31:0] rd);
    bit          lq = ld;
    bit          illegal, misal;
    int          sz, exp_lat, exp_reqs, edges, reqs, stall_bad;
    logic [1:0]  exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    bit          seen_done;

    illegal = lq ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2});
    sz      = 1 << f3[1:0];
    misal   = !illegal && (a % sz) != 0;
    if (illegal)               begin exp_fault = 2'b11; exp_lat = 1;     exp_reqs = 0;       end
    else if (misal)            begin exp_fault = 2'b01; exp_lat = 1;     exp_reqs = 0;       end
    else if (d < TIMEOUT)      begin exp_fault = 2'b00; exp_lat = d + 2; exp_reqs = d + 1;   end
    else                       begin exp_fault = 2'b10; exp_lat = TIMEOUT + 1; exp_reqs = TIMEOUT; end
    exp_be = 4'b0000;
    exp_wd = 32'h0;
    if (!lq) begin
      if (sz == 1)      begin exp_be = 4'(1 << (a % 4)); exp_wd = (sd % 256) * 32'h01010101; end
      else if (sz == 2) begin exp_be = 4'(3 << (a % 4)); exp_wd = (sd % 65536) * 32'h00010001; end
      else              begin exp_be = 4'hF;             exp_wd = sd; end
    end
    if (lq) exp_ld = (exp_fault == 2'b00) ? ref_load(f3, a, rd) : 32'h0;

    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'h0);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    mem_ack = 1'($urandom_range(0, 1));   // strobes outside ACCESS must be ignored
    mem_rdata = $urandom;
    #1 check("stall_req", {31'b0, stall}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;

    edges = 0; reqs = 0; stall_bad = 0; seen_done = 0;
    while (edges < 60 && !seen_done) begin
      @(negedge clk);
      edges++;
      mem_ack = 1'b0;
      if (done) begin
        seen_done = 1;
      end else begin
        if (!stall) stall_bad++;
        if (mem_req) begin
          reqs++;
          if (reqs == 1) begin
            check("mem_addr", mem_addr, a & 32'hFFFFFFFC);
            check("mem_we", {31'b0, mem_we}, {31'b0, !lq});
            check("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
            if (!lq) check("mem_wdata", mem_wdata, exp_wd);
          end
          if (reqs == d + 1) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
          end
        end
      end
    end
    check("done_seen", {31'b0, seen_done}, 32'h1);
    check("latency", edges, exp_lat);
    check("req_cycles", reqs, exp_reqs);
    check("stall_access", stall_bad, 0);
    check("fault", {30'b0, fault}, {30'b0, exp_fault});
    check("load_data", load_data, exp_ld);
    check("stall_done", {31'b0, stall}, 32'h0);
    check("req_dropped", {31'b0, mem_req}, 32'h0);
    $display("txn %s f3=%0d addr=0x%08h d=%0d fault=%0d load_data=0x%08h lat=%0d",
             lq ? "LD" : "ST", f3, a, d, fault, load_data, edges);
  endtask

  initial begin
    #12;
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_be", {28'b0, mem_be}, 32'h0);
    check("rst_fault", {30'b0, fault}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80AABBCC);        // LB
    txn(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80011234);        // LHU
    txn(1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80011234);        // LH
    txn(0, 1, 3'b000, 32'h101, 32'h000000A5, 4, 32'h0);        // SB, store keeps load_data
    txn(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);               // LW misaligned
    txn(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);               // illegal load
    txn(0, 1, 3'b100, 32'h100, 32'h12345678, 0, 32'h0);        // illegal store
    txn(1, 0, 3'b010, 32'h300, 32'h0, 99, 32'hDEADBEEF);       // timeout
    txn(1, 0, 3'b010, 32'h304, 32'h0, TIMEOUT - 1, 32'hCAFEF00D); // ack on last cycle
    txn(1, 1, 3'b100, 32'h7, 32'h0, 0, 32'h5A000000);          // both strobes: load wins

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0; is_load = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_req", {31'b0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, mem_req}, 32'h0);
    check("arst_stall", {31'b0, stall}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 0, 3'b010, 32'h200, 32'h0, 1, 32'h13579BDF);

    for (int i = 0; i < 150; i++) begin
      bit          ld, st;
      int          d;
      logic [2:0]  f3;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (ld && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = (f3[1:0] == 2'b10) ? (a & ~32'h3) :
                                          (f3[1:0] == 2'b01) ? (a & ~32'h1) : a;
      case ($urandom_range(0, 9))
        0:       d = 99;
        1:       d = TIMEOUT - 1;
        default: d = $urandom_range(0, 5);
      endcase
      txn(ld, st, f3, a, $urandom, d, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
